// File: rtl/postfix_pkg.sv
// Shared constants and state encoding for the postfix expression evaluator.
package postfix_pkg;

  localparam int unsigned DefStackDepth = 16;
  localparam int unsigned DefDataW      = 16;

  localparam logic [7:0] ChZero  = 8'h30;
  localparam logic [7:0] ChNine  = 8'h39;
  localparam logic [7:0] ChPlus  = 8'h2B;
  localparam logic [7:0] ChMinus = 8'h2D;
  localparam logic [7:0] ChMul   = 8'h2A;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StResult
  } state_t;

endpackage

// File: rtl/eval_stack.sv
// Registered operand stack: push, pop2-push1 (replace), clear; exposes top two entries and depth.
module eval_stack #(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DepthW      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              replace,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] second,
  output logic [DepthW-1:0] depth,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AddrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [DATA_W-1:0] mem [STACK_DEPTH];
  logic [DepthW-1:0] sp;
  logic [DepthW-1:0] base;

  // A clear in the same cycle as a push starts the new frame at slot 0.
  always_comb begin
    base   = clear ? '0 : sp;
    top    = mem[AddrW'(sp - DepthW'(1))];
    second = mem[AddrW'(sp - DepthW'(2))];
    depth  = sp;
    full   = (sp == DepthW'(STACK_DEPTH));
    empty  = (sp == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
    end else if (push) begin
      sp <= base + DepthW'(1);
    end else if (replace) begin
      sp <= base - DepthW'(1);
    end else if (clear) begin
      sp <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[AddrW'(base)] <= push_data;
    end else if (replace) begin
      mem[AddrW'(base - DepthW'(2))] <= push_data;
    end
  end

endmodule

// File: rtl/postfix_eval.sv
// Postfix expression evaluator: one ASCII character per cycle while ready is high,
// result/error reported with a one-cycle done pulse after the frame ends.
module postfix_eval
  import postfix_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = DefStackDepth,
  parameter int unsigned DATA_W      = DefDataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [7:0]        postfix,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              error
);

  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);

  state_t            state;
  logic              frame_err;
  logic [DATA_W-1:0] top;
  logic [DATA_W-1:0] second;
  logic [DATA_W-1:0] digit_val;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] push_data;
  logic [DepthW-1:0] depth;
  logic              full;
  logic              empty;
  logic              is_digit;
  logic              is_op;
  logic              first;
  logic              eff_err;
  logic              bad;
  logic              end_err;
  logic              clear;
  logic              push;
  logic              replace;

  always_comb begin
    is_digit  = (postfix >= ChZero) && (postfix <= ChNine);
    is_op     = (postfix == ChPlus) || (postfix == ChMinus) || (postfix == ChMul);
    // Outside ACCUM the incoming character opens a new frame: stack and error count as cleared.
    first     = (state != StAccum);
    eff_err   = first ? 1'b0 : frame_err;
    if (is_digit) begin
      bad = !first && full;
    end else if (is_op) begin
      bad = first || empty || (depth == DepthW'(1));
    end else begin
      bad = 1'b1;
    end
    digit_val = {{(DATA_W - 4){1'b0}}, postfix[3:0]};
    case (postfix)
      ChPlus:  alu_res = second + top;
      ChMinus: alu_res = second - top;
      default: alu_res = second * top;
    endcase
    push_data = is_digit ? digit_val : alu_res;
    clear     = ready && first;
    push      = ready && !eff_err && !bad && is_digit;
    replace   = ready && !eff_err && !bad && is_op;
    end_err   = frame_err || (depth != DepthW'(1));
  end

  eval_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .DATA_W     (DATA_W),
    .DepthW     (DepthW)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push     (push),
    .replace  (replace),
    .push_data(push_data),
    .top      (top),
    .second   (second),
    .depth    (depth),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      frame_err <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle, StResult: begin
          if (ready) begin
            state     <= StAccum;
            frame_err <= bad;
          end else begin
            state <= StIdle;
          end
        end
        StAccum: begin
          if (ready) begin
            frame_err <= frame_err | bad;
          end else begin
            state  <= StResult;
            done   <= 1'b1;
            error  <= end_err;
            result <= end_err ? '0 : top;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/postfix_eval.md
POSTFIX_EVAL -- requirements
Module: postfix_eval

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 16, operand stack entries.
REQ-002 SHALL have parameter DATA_W, default 16, signed operand/result width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have port ready  input  1  frame-valid from the infix-to-postfix converter; high for one contiguous run of cycles per expression.
REQ-006 SHALL have port postfix  input  8  ASCII postfix character, valid while ready=1.
REQ-007 SHALL have port done  output  1  one-cycle pulse marking a valid result/error.
REQ-008 SHALL have port result  output  DATA_W  signed expression value.
REQ-009 SHALL have port error  output  1  expression malformed.

Function
REQ-010 SHALL consume exactly one postfix character on every rising edge where ready=1; no back-pressure.
REQ-011 SHALL implement states IDLE, ACCUM, RESULT: IDLE->ACCUM on ready=1; ACCUM stays while ready=1; ACCUM->RESULT on first edge sampling ready=0; RESULT->IDLE, or RESULT->ACCUM if ready=1 in that cycle.
REQ-012 SHALL assert done for exactly the one cycle spent in RESULT, i.e. one cycle after ready falls.
REQ-013 SHALL treat '0'..'9' (0x30-0x39) as push of values 0..9.
REQ-014 SHALL treat '+' (0x2B), '-' (0x2D), '*' (0x2A) as: pop b (top), pop a, push a op b.
REQ-015 SHALL compute all arithmetic modulo 2^DATA_W, two's complement; '*' keeps low DATA_W bits; no saturation.
REQ-016 SHALL set a sticky frame error on: operator with fewer than 2 entries (underflow), digit push with stack full (overflow), any other character code.
REQ-017 SHALL, once the frame error is set, ignore the rest of the frame's stack operations.
REQ-018 SHALL at frame end set error=1 if the frame error is set or stack depth is not exactly 1.
REQ-019 SHALL drive result = top of stack when error=0, and result=0 when error=1.
REQ-020 SHALL update result and error only on entry to RESULT and hold them until the next done.
REQ-021 SHALL clear stack pointer and frame error at the start of every frame; a character arriving during RESULT is the first character of the new frame.

Reset
REQ-022 SHALL on reset=0 immediately force state IDLE, stack empty, frame error clear, done=0, result=0, error=0.
REQ-023 SHALL discard any partially received frame on reset; no done for it after release.
REQ-024 SHALL begin accepting characters on the first rising edge with reset=1 and ready=1.

Structure
REQ-025 SHALL place ASCII codes ('0', '9', '+', '-', '*'), default STACK_DEPTH/DATA_W and the state enum in shared package postfix_pkg.
REQ-026 SHALL implement the operand stack as sub-module eval_stack: push, pop2-push1 (replace), clear, exposes top two entries and depth, full/empty flags.
REQ-027 SHALL keep the state machine, decode and ALU in postfix_eval; stack storage registered, no memory macros.

Verification
REQ-028 SHALL check "23+" -> done one cycle after ready falls, result=5, error=0.
REQ-029 SHALL check "92-3*" -> result=21 (0x0015), error=0.
REQ-030 SHALL check wrap "99*9*9*9*" (59049) -> result=0xE6A9 (-6487), error=0; and "35-" -> result=0xFFFE.
REQ-031 SHALL check errors: "+" -> error=1 result=0; "12" -> error=1; "4a" -> error=1; 17 consecutive '1' -> error=1 (overflow).
REQ-032 SHALL check reset=0 asserted after "5" mid-frame -> outputs 0, no done; then frame "7" -> result=7, error=0.
REQ-033 SHALL check back-to-back frames "12+" then, with ready high in the RESULT cycle, "4" -> done results 3 then 4, both error=0.
